// File: rtl/iot_out_pkg.sv
// Shared constants for the IoT filter output stage: control FSM state code,
// default datapath geometry and default per-channel qualification masks.
package iot_out_pkg;

  localparam logic [2:0] ST_OUT = 3'b010;

  localparam int DEFAULT_DW         = 128;
  localparam int DEFAULT_N_FN       = 7;
  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_CNT_W      = 8;
  localparam int DEFAULT_LAST_CYCLE = 7;

  // Channels 1..3 emit on every OUT cycle; channels 6..7 also emit on the final flush cycle.
  localparam logic [DEFAULT_N_FN-1:0] DEFAULT_ALWAYS_MASK = 7'b0000111;
  localparam logic [DEFAULT_N_FN-1:0] DEFAULT_FLUSH_MASK  = 7'b1100000;

endpackage

// File: rtl/iot_sync_fifo.sv
// Small synchronous FIFO holding qualified output words behind the output register.
// A push is accepted while full as long as a pop happens on the same edge.
module iot_sync_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iot_out_stream.sv
// Output stage of the IoT filter datapath: picks the selected function channel,
// qualifies its result, buffers it and presents it on a ready/valid output.
// Total capacity is the output register plus DEPTH FIFO words.
module iot_out_stream
  import iot_out_pkg::*;
#(
  parameter int              DW          = DEFAULT_DW,
  parameter int              N_FN        = DEFAULT_N_FN,
  parameter int              DEPTH       = DEFAULT_DEPTH,
  parameter int              CNT_W       = DEFAULT_CNT_W,
  parameter int              LAST_CYCLE  = DEFAULT_LAST_CYCLE,
  parameter logic [N_FN-1:0] ALWAYS_MASK = DEFAULT_ALWAYS_MASK,
  parameter logic [N_FN-1:0] FLUSH_MASK  = DEFAULT_FLUSH_MASK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 state,
  input  logic [$clog2(N_FN+1)-1:0]  fn_sel,
  input  logic [N_FN*DW-1:0]         result_bus,
  input  logic [N_FN-1:0]            out_en_vec,
  input  logic                       flag,
  input  logic [CNT_W-1:0]           cycle_cnt,
  input  logic                       out_ready,
  output logic                       valid,
  output logic [DW-1:0]              iot_out,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       overflow
);

  localparam int SEL_W  = $clog2(N_FN+1);
  localparam int FILL_W = $clog2(DEPTH+1);

  logic [SEL_W-1:0]  sel;
  logic [DW-1:0]     sel_word;
  logic              flush_hit;
  logic              push;
  logic              out_free;
  logic              fifo_push;
  logic              fifo_pop;
  logic              load_fifo;
  logic              load_bypass;
  logic              drop;
  logic [DW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FILL_W-1:0] fifo_count;

  // Map fn_sel 1..N_FN onto channel 0..N_FN-1; anything out of range falls back to the last channel.
  always_comb begin
    sel = SEL_W'(N_FN - 1);
    if ((fn_sel != '0) && (fn_sel <= SEL_W'(N_FN))) begin
      sel = fn_sel - SEL_W'(1);
    end
  end

  // Pull the selected channel's result word out of the flattened result bus.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_FN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = result_bus[k*DW +: DW];
      end
    end
  end

  assign flush_hit = !flag && (cycle_cnt == CNT_W'(LAST_CYCLE));
  assign push      = (state == ST_OUT) &&
                     (ALWAYS_MASK[sel] || out_en_vec[sel] || (FLUSH_MASK[sel] && flush_hit));
  assign out_free  = !valid || out_ready;

  // Route each qualified word: refill the output register from the FIFO head first,
  // bypass straight into it when nothing is queued, otherwise queue or drop.
  always_comb begin
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    load_fifo   = 1'b0;
    load_bypass = 1'b0;
    drop        = 1'b0;
    if (out_free) begin
      if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        load_fifo = 1'b1;
        fifo_push = push;
      end else if (push) begin
        load_bypass = 1'b1;
      end
    end else if (push) begin
      if (fifo_full) begin
        drop = 1'b1;
      end else begin
        fifo_push = 1'b1;
      end
    end
  end

  iot_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (sel_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output register with zeroed data when idle, plus the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid    <= 1'b0;
      iot_out  <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (load_fifo) begin
        valid   <= 1'b1;
        iot_out <= fifo_rdata;
      end else if (load_bypass) begin
        valid   <= 1'b1;
        iot_out <= sel_word;
      end else if (out_free) begin
        valid   <= 1'b0;
        iot_out <= '0;
      end
    end
  end

  assign fill = fifo_count + FILL_W'(valid);

endmodule
